// File: rtl/rt_pkg.sv
// rt_pkg: shared state encoding, widths and defaults for the reaction-time game
package rt_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, ARMED, DONE, FAULT} state_t;
  localparam int RESULT_W = 14;
  localparam int TICK_DIV_DEF = 50000;
  localparam int MAX_MS_DEF = 9999;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], ^(x & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: one-cycle tick every TICK_DIV clocks, restartable via clear
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: random stimulus delay, then ms reaction measurement with
// false-start and timeout detection
module reaction_timer
  import rt_pkg::*;
#(
  parameter int          TICK_DIV     = TICK_DIV_DEF,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          DELAY_BITS   = 11,
  parameter int          MAX_MS       = MAX_MS_DEF,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                button,
  output logic                led,
  output logic                busy,
  output logic [RESULT_W-1:0] result_ms,
  output logic                result_valid,
  output logic                timeout,
  output logic                false_start
);
  localparam int DW = (DELAY_BITS + 1 > RESULT_W) ? DELAY_BITS + 1 : RESULT_W;
  state_t state, state_n;
  logic [15:0] lfsr;
  logic b_meta, b_sync, b_sync_d, start_d;
  logic press_edge, start_edge, tick, clear;
  logic [RESULT_W-1:0] ms_cnt, ms_n, ms_inc, result_n;
  logic [DW-1:0] delay_ms, delay_n;
  logic timeout_n, fs_n;
  assign press_edge = b_sync & ~b_sync_d;
  assign start_edge = start & ~start_d;
  assign ms_inc = ms_cnt + 1'b1;
  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      lfsr     <= LFSR_SEED;
      b_meta   <= 1'b0;
      b_sync   <= 1'b0;
      b_sync_d <= 1'b0;
      start_d  <= 1'b0;
    end else begin
      lfsr     <= lfsr_next(lfsr);
      b_meta   <= button;
      b_sync   <= b_meta;
      b_sync_d <= b_sync;
      start_d  <= start;
    end
  always_comb begin
    state_n   = state;
    ms_n      = ms_cnt;
    delay_n   = delay_ms;
    result_n  = result_ms;
    timeout_n = timeout;
    fs_n      = false_start;
    clear     = 1'b0;
    case (state)
      IDLE, DONE, FAULT:
        if (start_edge) begin
          state_n   = WAIT;
          delay_n   = DW'(MIN_DELAY_MS) + DW'(lfsr[DELAY_BITS-1:0]);
          ms_n      = '0;
          result_n  = '0;
          timeout_n = 1'b0;
          fs_n      = 1'b0;
          clear     = 1'b1;
        end
      WAIT:
        if (press_edge) begin
          state_n  = FAULT;
          fs_n     = 1'b1;
          result_n = '0;
        end else if (tick) begin
          ms_n = ms_inc;
          if (DW'(ms_inc) == delay_ms) begin
            state_n = ARMED;
            ms_n    = '0;
            clear   = 1'b1;
          end
        end
      ARMED:
        // a press in the tick cycle reports the count before that tick
        if (press_edge) begin
          state_n  = DONE;
          result_n = ms_cnt;
        end else if (tick) begin
          ms_n = ms_inc;
          if (ms_inc == RESULT_W'(MAX_MS)) begin
            state_n   = DONE;
            result_n  = RESULT_W'(MAX_MS);
            timeout_n = 1'b1;
          end
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state        <= IDLE;
      ms_cnt       <= '0;
      delay_ms     <= '0;
      result_ms    <= '0;
      timeout      <= 1'b0;
      false_start  <= 1'b0;
      led          <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      ms_cnt       <= ms_n;
      delay_ms     <= delay_n;
      result_ms    <= result_n;
      timeout      <= timeout_n;
      false_start  <= fs_n;
      led          <= state_n == ARMED;
      busy         <= state_n == WAIT || state_n == ARMED;
      result_valid <= state_n == DONE;
    end
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed trials checked per cycle against a phase/elapsed-time model
module tb_reaction_timer;
  localparam int TD = 10;
  localparam int MIN_D = 4;
  localparam int MAXMS = 50;
  logic clock = 0, reset = 0, start = 0, button = 0;
  logic led, busy, result_valid, timeout, false_start;
  logic [13:0] result_ms;
  int checks = 0, failures = 0;
  bit ready = 0;
  int led_cnt = 0;
  reaction_timer #(.TICK_DIV(TD), .MIN_DELAY_MS(MIN_D), .DELAY_BITS(3), .MAX_MS(MAXMS)) dut (
    .clock(clock), .reset(reset), .start(start), .button(button), .led(led), .busy(busy),
    .result_ms(result_ms), .result_valid(result_valid), .timeout(timeout), .false_start(false_start)
  );
  always #5 clock = ~clock;
  // model: phase 0 idle, 1 waiting, 2 lit, 3 done, 4 fault; el counts clocks spent in the phase
  logic [15:0] m_lfsr;
  logic h0, h1, h2, sp, m_to, m_fs;
  int ph, el, dly, res;
  function automatic logic [15:0] step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction
  always @(posedge clock or posedge reset) begin
    int nph, nel, ndly, nres;
    logic nto, nfs, press, sedge;
    if (reset) begin
      m_lfsr <= 16'hACE1; h0 <= 0; h1 <= 0; h2 <= 0; sp <= 0;
      ph <= 0; el <= 0; dly <= 0; res <= 0; m_to <= 0; m_fs <= 0;
    end else begin
      nph = ph; nel = el + 1; ndly = dly; nres = res; nto = m_to; nfs = m_fs;
      press = h1 && !h2;
      sedge = start && !sp;
      if (ph == 0 || ph == 3 || ph == 4) begin
        if (sedge) begin
          nph = 1; nel = 0; ndly = MIN_D + int'(m_lfsr % 8); nres = 0; nto = 0; nfs = 0;
        end
      end else if (ph == 1) begin
        if (press) begin nph = 4; nfs = 1; nres = 0; end
        else if (nel == ndly * TD) begin nph = 2; nel = 0; end
      end else begin
        if (press) begin nph = 3; nres = (nel - 1) / TD; end
        else if (nel == MAXMS * TD) begin nph = 3; nres = MAXMS; nto = 1; end
      end
      ph <= nph; el <= nel; dly <= ndly; res <= nres; m_to <= nto; m_fs <= nfs;
      h2 <= h1; h1 <= h0; h0 <= button; sp <= start; m_lfsr <= step(m_lfsr);
    end
  end
  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clock)
    if (ready && !reset) begin
      cmp("led", led, ph == 2);
      cmp("busy", busy, ph == 1 || ph == 2);
      cmp("result_valid", result_valid, ph == 3);
      cmp("result_ms", result_ms, res);
      cmp("timeout", timeout, m_to);
      cmp("false_start", false_start, m_fs);
    end
  always @(negedge clock) if (led) led_cnt++;
  task automatic pulse_start();
    start = 1;
    @(negedge clock);
    start = 0;
  endtask
  task automatic wait_for(input string name, input int sel, input int lim, output int n);
    n = 0;
    while (!(sel == 0 ? led : sel == 1 ? result_valid : false_start) && n < lim) begin
      @(negedge clock);
      n++;
    end
    cmp(name, sel == 0 ? led : sel == 1 ? result_valid : false_start, 1);
  endtask
  initial begin
    int n;
    #1 reset = 1;
    ready = 1;
    repeat (3) @(negedge clock);
    cmp("rst_led", led, 0); cmp("rst_busy", busy, 0); cmp("rst_valid", result_valid, 0);
    cmp("rst_result", result_ms, 0); cmp("rst_timeout", timeout, 0); cmp("rst_fs", false_start, 0);
    reset = 0;
    repeat (4) @(negedge clock);
    pulse_start();
    wait_for("normal_led_wait", 0, 300, n);
    repeat (250) @(negedge clock);
    button = 1;
    wait_for("normal_done_wait", 1, 50, n);
    cmp("normal_result", result_ms, 25); cmp("normal_timeout", timeout, 0); cmp("normal_led", led, 0);
    button = 0;
    repeat (5) @(negedge clock);
    led_cnt = 0;
    pulse_start();
    cmp("restart_done_busy", busy, 1); cmp("restart_done_valid", result_valid, 0);
    repeat (19) @(negedge clock);
    button = 1;
    wait_for("fault_wait", 2, 50, n);
    cmp("fault_result", result_ms, 0); cmp("fault_led_cycles", led_cnt, 0); cmp("fault_busy", busy, 0);
    button = 0;
    repeat (5) @(negedge clock);
    pulse_start();
    cmp("restart_fault_busy", busy, 1); cmp("restart_fault_fs", false_start, 0);
    wait_for("timeout_led_wait", 0, 300, n);
    led_cnt = 0;
    wait_for("timeout_done_wait", 1, 1000, n);
    cmp("timeout_led_cycles", led_cnt, MAXMS * TD); cmp("timeout_result", result_ms, MAXMS);
    cmp("timeout_flag", timeout, 1);
    button = 1;
    repeat (5) @(negedge clock);
    pulse_start();
    cmp("restart_timeout_flag", timeout, 0);
    wait_for("held_led_wait", 0, 300, n);
    cmp("held_no_fault", false_start, 0);
    button = 0;
    repeat (20) @(negedge clock);
    pulse_start();
    cmp("armed_start_ignored", led, 1);
    repeat (49) @(negedge clock);
    button = 1;
    wait_for("held_done_wait", 1, 50, n);
    cmp("held_result", result_ms, 7);
    button = 0;
    repeat (5) @(negedge clock);
    pulse_start();
    wait_for("rst_led_wait", 0, 300, n);
    repeat (30) @(negedge clock);
    #1 reset = 1;
    #1;
    cmp("arst_led", led, 0); cmp("arst_busy", busy, 0); cmp("arst_valid", result_valid, 0);
    cmp("arst_result", result_ms, 0); cmp("arst_timeout", timeout, 0); cmp("arst_fs", false_start, 0);
    @(negedge clock);
    reset = 0;
    pulse_start();
    wait_for("seed_led_wait", 0, 300, n);
    cmp("seed_delay_cycles", n, 50);
    repeat (10) @(negedge clock);
    button = 1;
    wait_for("seed_done_wait", 1, 50, n);
    cmp("seed_result", result_ms, 1);
    button = 0;
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Measurement side of the reaction-time game.
- On a start request (from the game's start/arming FSM), it waits a pseudo-random delay, then lights the stimulus LED and counts milliseconds until the player presses the response button.
- Reports the reaction time in ms, a false-start flag (press before the LED lights) or a timeout flag.
- Sits between the start FSM, the raw push-button, the stimulus LED and the display/score logic.

Parameters:
- TICK_DIV, 50000, clock cycles per 1 ms tick (50 MHz board clock).
- MIN_DELAY_MS, 1000, fixed part of the stimulus delay in ms.
- DELAY_BITS, 11, width of the random delay part; random delay is 0..2^DELAY_BITS-1 ms.
- MAX_MS, 9999, reaction timeout in ms; must fit in 14 bits.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clock
- start  in  1  synchronous start request from the start FSM; rising edge triggers a trial
- button  in  1  raw asynchronous response push-button, active-high
- led  out  1  stimulus LED; high only in ARMED
- busy  out  1  high in WAIT or ARMED
- result_ms  out  14  measured reaction time in ms; held until the next trial starts
- result_valid  out  1  high in DONE
- timeout  out  1  high in DONE when the trial ended at MAX_MS without a press
- false_start  out  1  high in FAULT

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; LFSR=LFSR_SEED; tick counter, ms counter and delay register cleared; synchronizer and edge flops cleared.
- button path: 2-flop synchronizer, then a registered edge detector. press_edge = sync & ~sync_d.
  - Latency from a button rising edge to press_edge is 2-3 cycles.
  - A button already held when a trial starts produces no press_edge until it is released and pressed again.
- start_edge = start & ~start_d, with start_d registered. start is not synchronized.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock, free-running in all states.
- Tick generator: counts 0..TICK_DIV-1 and pulses tick when it reaches TICK_DIV-1. Cleared to 0 on every entry to WAIT and to ARMED.
- States:
  - IDLE: on start_edge → WAIT. Load delay_ms = MIN_DELAY_MS + lfsr[DELAY_BITS-1:0] using the LFSR value in that cycle. Clear ms counter, result_ms, timeout and false_start.
  - WAIT: ms counter increments on each tick.
    - press_edge → FAULT; false_start=1. press_edge has priority over delay expiry in the same cycle.
    - Otherwise, when a tick makes ms counter == delay_ms → ARMED; ms counter cleared.
  - ARMED: led=1; ms counter increments on each tick.
    - press_edge → DONE; result_ms = ms counter value before any same-cycle increment. press_edge has priority over tick and timeout.
    - Otherwise, when a tick makes ms counter == MAX_MS → DONE; result_ms=MAX_MS, timeout=1.
  - DONE: result_valid=1; outputs held. On start_edge, same action as in IDLE.
  - FAULT: false_start=1; result_ms=0. On start_edge, same action as in IDLE.
- start_edge in WAIT or ARMED is ignored.
- All outputs are registered; state-decoded outputs update in the cycle after the transition.
- Width rules:
  - ms counter is 14 bits and never exceeds MAX_MS.
  - delay_ms is max(14, DELAY_BITS+1) bits; the addition is unsigned and cannot overflow for legal parameters.

Decomposition:
- Shared package rt_pkg holds:
  - state enum: IDLE, WAIT, ARMED, DONE, FAULT.
  - constant RESULT_W=14.
  - default TICK_DIV, MAX_MS and LFSR taps, so the display/score block reuses them.
- One sub-module, ms_tick_gen: parameter TICK_DIV; ports clock, reset, clear, tick.
- LFSR, synchronizer and FSM stay in reaction_timer.

Test Plan (bench overrides TICK_DIV=10, MIN_DELAY_MS=4, DELAY_BITS=3, MAX_MS=50; the bench model mirrors the LFSR to predict delay_ms):
- Normal trial: reset, start edge, button pressed 25 ticks after led rises → DONE; result_ms=25, result_valid=1, timeout=0, led=0.
- False start: start, button pressed 2 ticks after start (before led) → FAULT; false_start=1, led never asserted, result_ms=0.
- Timeout: start, no press → led high for exactly 50 ticks (500 cycles ±1), then result_ms=50, timeout=1, result_valid=1.
- Held button / ignored start: button held high through start and the whole WAIT → no FAULT; release then press 7 ticks after led → result_ms=7. A start edge during ARMED changes nothing.
- Reset mid-operation: assert reset during ARMED → led, busy and all outputs 0 immediately (async); LFSR back to seed; next start reproduces the predicted delay_ms.
- Restart from DONE/FAULT: start edge → busy=1 next cycle; result_valid, timeout and false_start cleared; delay_ms loaded from the LFSR value in the start-edge cycle.
